// File: rtl/fetch_sequencer_if.sv
// Fetch sequencer bundle: control, instruction-ROM read port and decode-side stream.
interface fetch_sequencer_if #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 4
) ();
    logic              start;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              rom_en_c;
    logic [ADDR_W-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_data;
    logic              inst_valid;
    logic              inst_ready;
    logic [WIDTH-1:0]  inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              busy;
    logic              halted;

    modport master (
        input  start, redirect, redirect_pc, rom_data, inst_ready,
        output rom_en_c, rom_addr, inst_valid, inst, inst_pc, busy, halted
    );

    modport slave (
        output start, redirect, redirect_pc, rom_data, inst_ready,
        input  rom_en_c, rom_addr, inst_valid, inst, inst_pc, busy, halted
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: issues ROM reads by PC and streams returned words
// to decode through a 2-entry FIFO, halting on a zero word or at end of ROM.
module fetch_sequencer #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_INST = 15,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              iClk,
    input  logic              iRstN,
    fetch_sequencer_if.master bus
);
    // One spare PC bit so NUM_INST == 2**ADDR_W still stops cleanly.
    localparam int unsigned     PC_W   = ADDR_W + 1;
    localparam int unsigned     DEPTH  = 2;
    localparam logic [PC_W-1:0] PC_END = PC_W'(NUM_INST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PC_W-1:0]   pc;
    logic              inflight;
    logic [ADDR_W-1:0] ret_pc;
    logic              halt_seen;
    logic [WIDTH-1:0]  fifo_inst [DEPTH];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic              rd_ptr;
    logic              wr_ptr;
    logic [1:0]        count;

    logic pop;
    logic push;
    logic issue;
    logic flush;
    logic restart;
    logic ret_noop;
    logic drained;

    // State register
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        push      = 1'b0;
        flush     = 1'b0;
        restart   = 1'b0;
        ret_noop  = 1'b0;
        pop       = (count != 2'd0) && bus.inst_ready;
        drained   = (count == 2'd0) && !inflight;
        case (state)
            S_IDLE, S_HALT: begin
                if (bus.start) begin
                    state_nxt = S_FETCH;
                    restart   = 1'b1;
                end
            end
            S_FETCH: begin
                if (bus.redirect) begin
                    flush = 1'b1;
                end else begin
                    // Credit: never issue more than the FIFO can absorb after this cycle's pop.
                    issue    = !halt_seen && (pc < PC_END) &&
                               (({1'b0, count} + 3'(inflight)) < (3'd2 + 3'(pop)));
                    push     = inflight && (bus.rom_data != '0) && !halt_seen;
                    ret_noop = inflight && (bus.rom_data == '0);
                    if (drained && (halt_seen || (pc >= PC_END))) begin
                        state_nxt = S_HALT;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // PC, in-flight tracking and FIFO pointers
    always_ff @(posedge iClk) begin
        if (!iRstN) begin
            pc        <= '0;
            inflight  <= 1'b0;
            ret_pc    <= '0;
            halt_seen <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else if (restart) begin
            pc        <= '0;
            halt_seen <= 1'b0;
        end else if (flush) begin
            pc        <= PC_W'(bus.redirect_pc);
            halt_seen <= 1'b0;
            inflight  <= 1'b0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= 2'd0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc     <= pc + PC_W'(1);
                ret_pc <= pc[ADDR_W-1:0];
            end
            if (ret_noop) begin
                halt_seen <= 1'b1;
            end
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // FIFO storage; contents are only observed through the valid-gated outputs
    always_ff @(posedge iClk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.rom_data;
            fifo_pc[wr_ptr]   <= ret_pc;
        end
    end

    assign bus.rom_en_c   = issue;
    assign bus.rom_addr   = pc[ADDR_W-1:0];
    assign bus.inst_valid = (count != 2'd0);
    assign bus.inst       = (count != 2'd0) ? fifo_inst[rd_ptr] : '0;
    assign bus.inst_pc    = (count != 2'd0) ? fifo_pc[rd_ptr] : '0;
    assign bus.busy       = (state == S_FETCH);
    assign bus.halted     = (state == S_HALT);
endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus random backpressure,
// restarts and redirects, compared against a queue-based model of ROM, FIFO and halt.
module tb_fetch_sequencer;
    localparam int unsigned WIDTH    = 32;
    localparam int unsigned NUM_INST = 15;
    localparam int unsigned ADDR_W   = 4;

    logic iClk  = 1'b0;
    logic iRstN = 1'b0;
    always #5 iClk = ~iClk;

    fetch_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    fetch_sequencer #(.WIDTH(WIDTH), .NUM_INST(NUM_INST), .ADDR_W(ADDR_W)) dut (
        .iClk  (iClk),
        .iRstN (iRstN),
        .bus   (bus)
    );

    // Synchronous 1-cycle-read ROM; word 14 is the NO-OP terminator
    logic [WIDTH-1:0] rom [16];
    always @(posedge iClk) begin
        if (bus.rom_en_c) bus.rom_data <= rom[bus.rom_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model: FIFO contents, one ROM return slot, next fetch address, run state
    int unsigned fq[$];
    bit          ret_v;
    int unsigned ret_a;
    int unsigned next_addr;
    bit          running;
    bit          m_halted;
    int          cyc;
    int unsigned xlog[$];
    int          first_xfer;
    int          last_xfer;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        ret_v     = 1'b0;
        ret_a     = 0;
        next_addr = 0;
        running   = 1'b0;
        m_halted  = 1'b0;
    endtask

    // One clock: drive inputs at negedge, check outputs against the model, then advance it
    task automatic cycle(input bit st, input bit rd, input bit rdy, input logic [ADDR_W-1:0] rpc);
        bit          pop;
        bit          exp_en;
        bit          drained;
        int          occ;
        int unsigned na_pre;
        @(negedge iClk);
        bus.start       = st;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
        #1;
        occ    = fq.size() + int'(ret_v);
        pop    = (fq.size() != 0) && rdy;
        exp_en = running && !rd && (next_addr < NUM_INST) && (occ < 2 + int'(pop));
        chk("inst_valid", 64'(bus.inst_valid), 64'(fq.size() != 0));
        if (fq.size() != 0) begin
            chk("inst_pc", 64'(bus.inst_pc), 64'(fq[0]));
            chk("inst", 64'(bus.inst), 64'(rom[4'(fq[0])]));
        end
        chk("rom_en", 64'(bus.rom_en_c), 64'(exp_en));
        if (exp_en) chk("rom_addr", 64'(bus.rom_addr), 64'(next_addr));
        chk("busy", 64'(bus.busy), 64'(running));
        chk("halted", 64'(bus.halted), 64'(m_halted));
        if (bus.inst_valid && rdy) begin
            xlog.push_back(32'(bus.inst_pc));
            if (first_xfer < 0) first_xfer = cyc;
            last_xfer = cyc;
        end
        drained = (fq.size() == 0) && !ret_v;
        na_pre  = next_addr;
        @(posedge iClk);
        cyc++;
        if (running) begin
            if (rd) begin
                fq.delete();
                ret_v     = 1'b0;
                next_addr = 32'(rpc);
            end else begin
                if (pop) void'(fq.pop_front());
                if (ret_v && rom[4'(ret_a)] != '0) fq.push_back(ret_a);
                ret_v = exp_en;
                if (exp_en) begin
                    ret_a     = next_addr;
                    next_addr = next_addr + 1;
                end
                if (drained && na_pre >= NUM_INST) begin
                    running  = 1'b0;
                    m_halted = 1'b1;
                end
            end
        end else if (st) begin
            running   = 1'b1;
            m_halted  = 1'b0;
            next_addr = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge iClk);
        iRstN           = 1'b0;
        bus.start       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.inst_ready  = 1'b0;
        @(posedge iClk);
        cyc++;
        #1;
        model_reset();
        chk("rst_valid", 64'(bus.inst_valid), 64'(0));
        chk("rst_inst", 64'(bus.inst), 64'(0));
        chk("rst_inst_pc", 64'(bus.inst_pc), 64'(0));
        chk("rst_rom_en", 64'(bus.rom_en_c), 64'(0));
        chk("rst_rom_addr", 64'(bus.rom_addr), 64'(0));
        chk("rst_busy", 64'(bus.busy), 64'(0));
        chk("rst_halted", 64'(bus.halted), 64'(0));
        @(negedge iClk);
        iRstN = 1'b1;
    endtask

    task automatic new_log();
        xlog.delete();
        first_xfer = -1;
        last_xfer  = -1;
    endtask

    // Compare the recorded transfer order against [0..pre] followed by [from..13]
    task automatic chk_seq(input string tag, input int pre, input int from);
        int unsigned exp_q[$];
        for (int i = 0; i <= pre; i++) exp_q.push_back(i);
        for (int i = from; i < 14; i++) exp_q.push_back(i);
        chk({tag, "_len"}, 64'(xlog.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < xlog.size(); i++) begin
            chk({tag, "_pc"}, 64'(xlog[i]), 64'(exp_q[i]));
        end
    endtask

    initial begin
        int  t0;
        bit  done;
        for (int i = 0; i < 16; i++) rom[i] = $urandom | 32'h1;
        rom[14] = '0;
        cyc        = 0;
        first_xfer = -1;
        last_xfer  = -1;
        model_reset();
        do_reset();

        // Full stream, ready held high: PCs 0..13 back to back, first at T0+3
        new_log();
        t0 = cyc;
        cycle(1'b1, 1'b0, 1'b1, '0);
        for (int i = 0; i < 60 && !m_halted; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        chk_seq("t1", -1, 0);
        chk("t1_latency", 64'(first_xfer), 64'(t0 + 3));
        chk("t1_back_to_back", 64'(last_xfer - first_xfer), 64'(13));

        // Restart from HALT with ready toggling; a start pulse mid-stream is ignored
        new_log();
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 100 && !m_halted; i++) cycle(i == 6, 1'b0, (i % 2) == 0, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        chk_seq("t2", -1, 0);

        // Redirect to 9 while head is PC 3 and accepted in the same cycle
        new_log();
        done = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 120 && !m_halted; i++) begin
            if (!done && fq.size() != 0 && fq[0] == 3) begin
                cycle(1'b0, 1'b1, 1'b1, 4'd9);
                done = 1'b1;
            end else begin
                cycle(1'b0, 1'b0, 1'($urandom % 2), '0);
            end
        end
        cycle(1'b0, 1'b0, 1'b1, '0);
        chk_seq("t3", 3, 9);

        // Redirect past end of ROM: nothing more issued, halted within two cycles
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'($urandom % 2), '0);
        cycle(1'b0, 1'b1, 1'b0, 4'd15);
        cycle(1'b0, 1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, 1'b1, '0);
        chk("t4_halted", 64'(bus.halted), 64'(1));
        chk("t4_flushed", 64'(bus.inst_valid), 64'(0));

        // Random backpressure, start pulses and redirect targets
        for (int r = 0; r < 4; r++) begin
            cycle(1'b1, 1'b0, 1'($urandom % 2), '0);
            for (int i = 0; i < 80; i++) begin
                cycle(($urandom % 10) == 0, ($urandom % 12) == 0,
                      1'($urandom % 2), 4'($urandom_range(0, 15)));
            end
        end

        // Reset mid-stream with the FIFO full: everything discarded, no transfer afterwards
        cycle(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, '0);
        chk("t6_full", 64'(bus.inst_valid), 64'(1));
        do_reset();
        new_log();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, '0);
        chk("t6_no_xfer", 64'(xlog.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
